demux_1x2_28bit_reg: RTL
========================

DEMUX_1X2_28BIT_REG -- requirements
Module: demux_1x2_28bit_reg

Interface
- REQ-001 SHALL have parameter WIDTH, default 28, meaning the mantissa data width.
- REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each delivered-word counter.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port in_valid, input, 1, meaning a source word is offered.
- REQ-006 SHALL have port in_ready, output, 1, meaning the offered word is accepted this cycle.
- REQ-007 SHALL have port in_data, input, WIDTH, the offered word.
- REQ-008 SHALL have port in_sel, input, 1, the destination: 0 routes to out0, 1 routes to out1.
- REQ-009 SHALL have ports out0_valid/out1_valid, output, 1 each, meaning the buffer head is valid.
- REQ-010 SHALL have ports out0_ready/out1_ready, input, 1 each, meaning the sink takes the head.
- REQ-011 SHALL have ports out0_data/out1_data, output, WIDTH each, the buffer head word.
- REQ-012 SHALL have ports cnt0/cnt1, output, CNT_W each, the count of words delivered on each output.

Function
- REQ-013 SHALL give each output a private 2-entry FIFO with occupancy states EMPTY, ONE, TWO.
- REQ-014 SHALL drive in_ready = 1 exactly when the FIFO selected by in_sel is not in TWO; the signal is combinational from in_sel and occupancy.
- REQ-015 SHALL accept a word on a cycle where in_valid and in_ready are both high, and write it into the selected FIFO only.
- REQ-016 SHALL present an accepted word on outN_valid/outN_data in the cycle after acceptance when that FIFO was EMPTY (latency 1); there is no combinational in-to-out path.
- REQ-017 SHALL pop on outN_valid and outN_ready; outN_data SHALL hold stable while outN_valid is high and outN_ready is low.
- REQ-018 SHALL use these transitions: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE, with the new word at the head; TWO+pop->ONE, with the second word promoted; TWO does not accept a push.
- REQ-019 SHALL preserve FIFO order per output; there is no ordering relation between out0 and out1.
- REQ-020 SHALL let a stalled output leave the other output unaffected: words routed to the free side are accepted at full rate.
- REQ-021 SHALL ignore in_data and in_sel when in_valid is low, with no state change.
- REQ-022 SHALL increment cntN by 1 on every outN pop; it wraps from 2^CNT_W-1 to 0 with no flag.
- REQ-023 SHALL sustain one transfer per cycle through one output when its sink holds outN_ready high.

Reset
- REQ-024 SHALL, with reset high at a clock edge, set both FIFOs to EMPTY, out0_valid=out1_valid=0, out0_data=out1_data=0 and cnt0=cnt1=0.
- REQ-025 SHALL discard words in flight on reset mid-operation; while reset is high in_ready is 0 and no push or pop is counted.
- REQ-026 SHALL resume normal acceptance on the first edge after reset deasserts.

Structure
- REQ-027 SHALL place the WIDTH default, the CNT_W default and the occupancy enum (EMPTY, ONE, TWO) in shared package fp_demux_pkg.
- REQ-028 SHALL implement each output path in sub-module demux_out_buf (2-entry FIFO plus its counter), instantiated twice; the top contains the routing and in_ready logic only.

Verification
- REQ-029 Basic routing: SHALL check that in_data=28'd1 with sel=0, then 28'd2 with sel=1, both readies high, give out0_data=1 one cycle after acceptance, then out1_data=2 one cycle later; cnt0=1 and cnt1=1.
- REQ-030 Backpressure: SHALL check that with out0_ready=0 and 28'hA, 28'hB, 28'hC offered to sel=0, A and B are accepted and in_ready=0 for C; after out0_ready=1 the outputs are A, B, C in order and cnt0=3.
- REQ-031 Independence: SHALL check that with out0 stalled at TWO, 28'h5 with sel=1 is accepted immediately and appears on out1 one cycle later.
- REQ-032 Simultaneous push and pop: SHALL check that with out0 in ONE holding 28'h10, pushing 28'h11 while popping leaves ONE with head 28'h11 and cnt0 incremented by 1.
- REQ-033 Reset mid-operation: SHALL check that with both FIFOs at TWO, a 1-cycle reset gives all valids 0, data 0, counts 0, and in_ready=1 on the next cycle.
- REQ-034 Counter wrap: SHALL check that 65536 back-to-back transfers on out1 return cnt1 to 0.

Source files
------------

// File: rtl/fp_demux_pkg.sv
// Shared defaults and FIFO occupancy encoding for the registered 1x2 mantissa demux.
package fp_demux_pkg;

    localparam int unsigned WIDTH_DEF = 28;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_t;

endpackage

// File: rtl/demux_out_buf.sv
// One demux output path: a 2-entry FIFO with registered head plus a delivered-word counter.
module demux_out_buf
    import fp_demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] cnt
);

    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;

    assign out_valid = (occ_q != EMPTY);
    assign full      = (occ_q == TWO);
    assign out_data  = head_q;
    assign cnt       = cnt_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = pop ? cnt_q + CNT_W'(1) : cnt_q;
        case (occ_q)
            EMPTY: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                // Push with pop: the head leaves and the new word takes its place.
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d = push_data;
                    occ_d  = TWO;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_1x2_28bit_reg.sv
// Registered 1-to-2 demux: routes each accepted word to the output chosen by in_sel.
module demux_1x2_28bit_reg
    import fp_demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic full0, full1;
    logic push0, push1;

    // Ready depends only on the selected buffer's occupancy, never on its sink.
    assign in_ready = !reset && (in_sel ? !full1 : !full0);
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready && in_sel;

    demux_out_buf #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_buf0 (
        .clk      (clk),
        .reset    (reset),
        .push     (push0),
        .push_data(in_data),
        .full     (full0),
        .out_valid(out0_valid),
        .out_ready(out0_ready),
        .out_data (out0_data),
        .cnt      (cnt0)
    );

    demux_out_buf #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_buf1 (
        .clk      (clk),
        .reset    (reset),
        .push     (push1),
        .push_data(in_data),
        .full     (full1),
        .out_valid(out1_valid),
        .out_ready(out1_ready),
        .out_data (out1_data),
        .cnt      (cnt1)
    );

endmodule
